// File: rtl/pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo
//
// Elastic inter-stage pipeline buffer (replaces a fixed single-entry F/D,
// D/E, E/M or M/W register). Holds up to DEPTH payloads of DATA_W bits in a
// circular array, with valid/ready handshakes on both sides, hazard-unit
// stall/flush, occupancy flags and a saturating count of flushed entries.
//
// Parameters
//   DATA_W  payload width in bits
//   DEPTH   number of entries (power of two, >= 2)
//   BYPASS  0: registered, 1-cycle latency
//           1: empty-buffer pass-through, 0-cycle latency
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   buffer can accept this cycle (independent of out_ready)
//   out_valid  payload available downstream
//   out_data   head payload
//   out_ready  downstream accepts
//   stall      hazard stall, masks out_ready
//   flush      discard all held and incoming entries
//   count      current occupancy
//   full       count == DEPTH
//   empty      count == 0
//   drop_cnt   entries discarded by flush, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module pipe_stage_fifo #(
  parameter int unsigned DATA_W = 97,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned BYPASS = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  input  logic                         stall,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [15:0]                  drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              full_w, empty_w;
  logic              rdy, push, pop;
  logic              pass_thru, wr_en, rd_en;
  logic [16:0]       drop_sum;

  // -------------------------------------------------------------------------
  // Handshake and flags
  // -------------------------------------------------------------------------
  always_comb begin
    empty_w  = (count_q == '0);
    full_w   = (count_q == CNT_W'(DEPTH));
    in_ready = ~full_w & ~flush & reset;

    if (BYPASS != 0) begin
      out_valid = (~empty_w | in_valid) & ~flush & reset;
      out_data  = empty_w ? in_data : mem_q[rd_ptr_q];
    end else begin
      out_valid = ~empty_w & ~flush & reset;
      out_data  = mem_q[rd_ptr_q];
    end

    rdy  = out_ready & ~stall;
    push = in_valid & in_ready;
    pop  = out_valid & rdy;

    // With an empty bypass buffer, a pop can only consume the incoming
    // payload; it goes straight through and never touches storage.
    pass_thru = (BYPASS != 0) && empty_w && push && pop;
    wr_en     = push & ~pass_thru;
    rd_en     = pop & ~pass_thru;
  end

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = 17'(drop_cnt_q) + 17'(count_q);

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; wr_en already implies reset high and no flush.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign count    = count_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_fifo
//
// Directed bench for pipe_stage_fifo. Four instances share one stimulus
// bus; sel routes the handshake inputs to one instance at a time (the rest
// see in_valid/out_ready/stall/flush low) and muxes that instance's outputs
// onto the observed signals.
//   sel 0: DEPTH=2,   BYPASS=0
//   sel 1: DEPTH=4,   BYPASS=0
//   sel 2: DEPTH=2,   BYPASS=1
//   sel 3: DEPTH=256, BYPASS=0 (drop counter saturation)
// ---------------------------------------------------------------------------
module tb_pipe_stage_fifo;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic        in_valid, out_ready, stall, flush;
  logic [15:0] in_data;

  logic [3:0]  iv_g, or_g, st_g, fl_g;
  logic [3:0]  ir_w, ov_w, full_w, empty_w;
  logic [15:0] od_w [4];
  logic [15:0] dc_w [4];
  logic [1:0]  c0;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic [8:0]  c3;

  logic        ir, ov, fl, em;
  logic [15:0] od, dc;
  logic [8:0]  cnt;

  int compared;
  int mism;

  logic        hold_pending;
  logic [15:0] held_data;

  int iv_t  [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  int st_t  [12] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
  int ov_t  [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int od_t  [12] = '{'h00, 'h11, 'h11, 'h12, 'h12, 'h13, 'h13, 'h14, 'h14, 'h15, 'h16, 'h00};
  int cnt_t [12] = '{0, 1, 2, 2, 3, 3, 4, 3, 3, 2, 1, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      iv_g[k] = in_valid  && (sel == 2'(k));
      or_g[k] = out_ready && (sel == 2'(k));
      st_g[k] = stall     && (sel == 2'(k));
      fl_g[k] = flush     && (sel == 2'(k));
    end
  end

  pipe_stage_fifo #(.DATA_W(16), .DEPTH(2), .BYPASS(0)) u_d2 (
    .clk(clk), .reset(rst_n), .in_valid(iv_g[0]), .in_data(in_data),
    .in_ready(ir_w[0]), .out_valid(ov_w[0]), .out_data(od_w[0]),
    .out_ready(or_g[0]), .stall(st_g[0]), .flush(fl_g[0]), .count(c0),
    .full(full_w[0]), .empty(empty_w[0]), .drop_cnt(dc_w[0])
  );

  pipe_stage_fifo #(.DATA_W(16), .DEPTH(4), .BYPASS(0)) u_d4 (
    .clk(clk), .reset(rst_n), .in_valid(iv_g[1]), .in_data(in_data),
    .in_ready(ir_w[1]), .out_valid(ov_w[1]), .out_data(od_w[1]),
    .out_ready(or_g[1]), .stall(st_g[1]), .flush(fl_g[1]), .count(c1),
    .full(full_w[1]), .empty(empty_w[1]), .drop_cnt(dc_w[1])
  );

  pipe_stage_fifo #(.DATA_W(16), .DEPTH(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(rst_n), .in_valid(iv_g[2]), .in_data(in_data),
    .in_ready(ir_w[2]), .out_valid(ov_w[2]), .out_data(od_w[2]),
    .out_ready(or_g[2]), .stall(st_g[2]), .flush(fl_g[2]), .count(c2),
    .full(full_w[2]), .empty(empty_w[2]), .drop_cnt(dc_w[2])
  );

  pipe_stage_fifo #(.DATA_W(16), .DEPTH(256), .BYPASS(0)) u_sat (
    .clk(clk), .reset(rst_n), .in_valid(iv_g[3]), .in_data(in_data),
    .in_ready(ir_w[3]), .out_valid(ov_w[3]), .out_data(od_w[3]),
    .out_ready(or_g[3]), .stall(st_g[3]), .flush(fl_g[3]), .count(c3),
    .full(full_w[3]), .empty(empty_w[3]), .drop_cnt(dc_w[3])
  );

  always_comb begin
    ir = ir_w[sel];
    ov = ov_w[sel];
    fl = full_w[sel];
    em = empty_w[sel];
    od = od_w[sel];
    dc = dc_w[sel];
    case (sel)
      2'd0:    cnt = 9'(c0);
      2'd1:    cnt = 9'(c1);
      2'd2:    cnt = 9'(c2);
      default: cnt = c3;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are already settled. Upstream stimulus must
  // keep in_data steady while a valid payload is being refused.
  task automatic tick();
    assert (!(hold_pending && in_valid && (in_data !== held_data))) else begin
      mism++;
      $error("FAIL hold_in_data: observed %0h expected %0h", in_data, held_data);
    end
    hold_pending = in_valid && !ir && rst_n;
    held_data    = in_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared     = 0;
    mism         = 0;
    hold_pending = 1'b0;
    held_data    = '0;
    sel          = 2'd0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready_low", 32'(ir), 0);
    chk("rst_out_valid_low", 32'(ov), 0);
    chk("rst_count", 32'(cnt), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", 32'(em), 1);
    chk("post_rst_full", 32'(fl), 0);
    chk("post_rst_out_valid", 32'(ov), 0);
    chk("post_rst_in_ready", 32'(ir), 1);
    chk("post_rst_drop_cnt", 32'(dc), 0);

    // Fill / drain, DEPTH=2
    in_valid = 1'b1; in_data = 16'h000A; out_ready = 1'b0;
    #1;
    chk("fill_in_ready", 32'(ir), 1);
    tick();
    chk("fill1_count", 32'(cnt), 1);
    chk("fill1_out_valid", 32'(ov), 1);
    chk("fill1_out_data", 32'(od), 'hA);
    in_data = 16'h000B;
    tick();
    chk("fill2_count", 32'(cnt), 2);
    chk("fill2_full", 32'(fl), 1);
    chk("fill2_in_ready", 32'(ir), 0);
    chk("fill2_out_data", 32'(od), 'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("drain_head_a", 32'(od), 'hA);
    tick();
    chk("drain_head_b", 32'(od), 'hB);
    chk("drain_count", 32'(cnt), 1);
    tick();
    chk("drain_empty", 32'(em), 1);
    chk("drain_out_valid", 32'(ov), 0);

    // Throughput, DEPTH=2
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      #1;
      if (i == 1) begin
        chk("thr_first_out_valid", 32'(ov), 0);
      end else begin
        chk("thr_out_valid", 32'(ov), 1);
        chk("thr_out_data", 32'(od), 32'(i - 1));
        chk("thr_count", 32'(cnt), 1);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("thr_last_data", 32'(od), 8);
    tick();
    chk("thr_end_empty", 32'(em), 1);

    // Bypass, DEPTH=2
    sel = 2'd2;
    in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b1;
    #1;
    chk("byp_out_valid", 32'(ov), 1);
    chk("byp_out_data", 32'(od), 'h55);
    chk("byp_count", 32'(cnt), 0);
    tick();
    chk("byp_count_after", 32'(cnt), 0);
    chk("byp_empty_after", 32'(em), 1);
    in_data = 16'h0066; out_ready = 1'b0;
    #1;
    chk("byp_blocked_data", 32'(od), 'h66);
    tick();
    chk("byp_stored_count", 32'(cnt), 1);
    chk("byp_stored_data", 32'(od), 'h66);
    in_data = 16'h0077; out_ready = 1'b1;
    #1;
    chk("byp_head_not_input", 32'(od), 'h66);
    tick();
    chk("byp_pushpop_count", 32'(cnt), 1);
    chk("byp_pushpop_data", 32'(od), 'h77);
    in_valid = 1'b0;
    tick();
    chk("byp_drained", 32'(em), 1);

    // Flush with occupancy, DEPTH=4
    sel = 2'd1;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 16'(i);
      tick();
    end
    chk("fl_pre_count", 32'(cnt), 3);
    in_data = 16'h0044; flush = 1'b1;
    #1;
    chk("fl_in_ready_gated", 32'(ir), 0);
    chk("fl_out_valid_gated", 32'(ov), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_count", 32'(cnt), 0);
    chk("fl_out_valid", 32'(ov), 0);
    chk("fl_drop_cnt", 32'(dc), 3);
    out_ready = 1'b1;
    tick();
    chk("fl_inflight_dropped", 32'(ov), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_empty_flush_drop", 32'(dc), 3);

    // Stall / wrap-around, DEPTH=4 (pointers restart at 0 after the flush)
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (iv_t[i] != 0);
      if (i < 6) in_data = 16'h0011 + 16'(i);
      stall = (st_t[i] != 0);
      #1;
      chk("wrap_out_valid", 32'(ov), 32'(ov_t[i]));
      if (ov_t[i] != 0) chk("wrap_out_data", 32'(od), 32'(od_t[i]));
      chk("wrap_count", 32'(cnt), 32'(cnt_t[i]));
      tick();
    end
    stall = 1'b0; in_valid = 1'b0;

    // Reset mid-fill, DEPTH=4
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0021;
    tick();
    in_data = 16'h0022;
    tick();
    chk("rmid_pre_count", 32'(cnt), 2);
    rst_n = 1'b0; in_data = 16'h0023;
    #1;
    chk("rmid_in_ready", 32'(ir), 0);
    chk("rmid_out_valid", 32'(ov), 0);
    tick();
    chk("rmid_count", 32'(cnt), 0);
    chk("rmid_drop_cnt", 32'(dc), 0);
    chk("rmid_in_ready_held", 32'(ir), 0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("rmid_rel_in_ready", 32'(ir), 1);
    chk("rmid_rel_out_valid", 32'(ov), 0);
    chk("rmid_rel_empty", 32'(em), 1);

    // drop_cnt saturation, DEPTH=256: 255 full flushes give 0xFF00
    sel = 2'd3;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h005A;
    for (int f = 0; f < 255; f++) begin
      repeat (256) tick();
      if (f == 0) chk("sat_full", 32'(fl), 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    chk("sat_ff00", 32'(dc), 'hFF00);
    repeat (255) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_exact_ffff", 32'(dc), 'hFFFF);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_hold_ffff", 32'(dc), 'hFFFF);
    chk("sat_count_cleared", 32'(cnt), 0);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
- Parametrised elastic pipeline-stage buffer that replaces a fixed single-entry inter-stage register (F/D, D/E, E/M, M/W).
- Holds DEPTH entries of an arbitrary packed stage payload of DATA_W bits.
- Upstream and downstream use valid/ready handshakes. Also accepts the hazard unit's stall and flush.
- Adds optional zero-latency bypass, occupancy reporting and a saturating flush-drop counter.

Parameters:
DATA_W, 97, payload width in bits (default = 32-bit instr + 64-bit pc + valid)
DEPTH, 2, number of entries; power of two, >= 2
BYPASS, 0, 0 = registered (1-cycle latency); 1 = empty-buffer pass-through (0-cycle latency)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous active-low reset (state clears on a clk edge while reset==0)
in_valid  in  1  upstream payload valid
in_data  in  DATA_W  upstream payload
in_ready  out  1  buffer can accept this cycle
out_valid  out  1  payload available downstream
out_data  out  DATA_W  head payload
out_ready  in  1  downstream accepts
stall  in  1  hazard stall for this stage; forces effective out_ready to 0
flush  in  1  discard all held and incoming entries
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
drop_cnt  out  16  entries discarded by flush, saturating

Behaviour:
- Storage: circular array of DEPTH entries. wr_ptr, rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is held separately.
- Reset (reset==0 at an edge):
  - count, wr_ptr, rd_ptr and drop_cnt go to 0.
  - Storage contents are don't-care.
  - While reset==0: in_ready=0 and out_valid=0.
  - After release: empty=1, full=0, out_valid=0, in_ready=1.
- Effective downstream ready: rdy = out_ready & ~stall.
- in_ready = ~full & ~flush & reset. No combinational dependence on out_ready.
- BYPASS=0:
  - out_valid = ~empty & ~flush.
  - out_data = mem[rd_ptr].
  - Minimum latency from in_valid to out_valid is 1 cycle.
- BYPASS=1:
  - out_valid = (~empty | in_valid) & ~flush.
  - When empty, out_data = in_data; otherwise out_data = mem[rd_ptr].
- push = in_valid & in_ready.
- pop = out_valid & rdy.
- Pass-through case (BYPASS=1, empty, push & pop): the payload is consumed directly. Nothing is written, and count and pointers are unchanged.
- Other simultaneous push & pop: write at wr_ptr and read at rd_ptr. Both pointers advance and count is unchanged.
  - When full, push cannot occur, because in_ready is 0.
- Push only: write mem[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- flush (highest priority after reset):
  - At the edge: count, wr_ptr and rd_ptr go to 0. The in_data of that cycle is dropped. No transfer occurs on either side that cycle, since in_ready and out_valid are gated.
  - drop_cnt += count sampled that cycle, saturating at 16'hFFFF.
  - A flush with count==0 leaves drop_cnt unchanged.
- stall:
  - Holds contents; out_data stays stable while out_valid=1 and no pop occurs.
  - Upstream may continue filling until full.
  - stall and flush together behave as flush.
- Handshake contract:
  - Once out_valid=1 without flush, out_valid and out_data hold until pop.
  - Upstream must hold in_data while in_valid & ~in_ready. This is assertion-checked in the bench, not enforced by the block.
- Reset mid-operation: all held entries are lost without incrementing drop_cnt.

Test Plan:
- Basic fill/drain, DEPTH=2, BYPASS=0:
  - Push 0xA then 0xB with out_ready=0 -> count=2, full=1, in_ready=0.
  - Then out_ready=1 -> 0xA, then 0xB on consecutive cycles; empty=1 after.
- Throughput: continuous in_valid with out_ready=1, 8 payloads 1..8, BYPASS=0 -> out_valid from cycle 1, one payload per cycle in order, count steady at 1.
- Bypass: BYPASS=1, empty, in_valid=1, in_data=0x55, out_ready=1 -> out_valid=1 and out_data=0x55 same cycle; count stays 0.
- Flush with occupancy: 3 entries held (DEPTH=4) plus in_valid on the flush cycle -> next cycle count=0, out_valid=0, drop_cnt=3. The in-flight payload never appears at the output.
- Stall / wrap-around: DEPTH=4, push 6 entries interleaved with pops while stall toggles -> FIFO order preserved across the pointer wrap. out_data is stable on every stall cycle.
- Reset / saturation:
  - reset=0 mid-fill -> count=0, in_ready=0 during reset, drop_cnt=0.
  - Separately, preload drop_cnt near 0xFFFF via repeated full flushes -> it holds at 0xFFFF.
